// File: rtl/key_sequencer.sv
// key_sequencer: cartridge key sequencer. Reads inside the key window must
// present the command nibble the LFSR currently expects. A full run of
// matches unlocks response streaming. Mismatches reseed the LFSR, and
// repeated failures force a timed lockout.
`timescale 1ns/1ps
module key_sequencer #(
  parameter int                 STATE_W     = 6,
  parameter int                 ADDR_W      = 4,
  parameter int                 DATA_W      = 2,
  parameter logic [STATE_W-1:0] TAPS        = 6'h30,
  parameter logic [STATE_W-1:0] SEED        = 6'h2D,
  parameter int                 SEQ_LEN     = 4,
  parameter int                 MAX_FAIL    = 3,
  parameter int                 LOCKOUT_CYC = 16,
  parameter logic [ADDR_W-1:0]  RELOCK      = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sser_n,
  input  logic              ba13,
  input  logic              ba12,
  input  logic [ADDR_W-1:0] ba_cmd,
  input  logic              br_w,
  input  logic              bus_valid,
  output logic [DATA_W-1:0] sd_out,
  output logic              sd_oe,
  output logic              unlocked,
  output logic              locked_out
);

  localparam int STEP_W  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN + 1) : 1;
  localparam int FAIL_W  = (MAX_FAIL > 1) ? $clog2(MAX_FAIL + 1) : 1;
  localparam int TIMER_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(SEQ_LEN - 1);
  localparam logic [FAIL_W-1:0]  FAIL_LAST  = FAIL_W'(MAX_FAIL - 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(LOCKOUT_CYC - 1);

  localparam logic [1:0] ST_LOCKED   = 2'd0;
  localparam logic [1:0] ST_TRACK    = 2'd1;
  localparam logic [1:0] ST_UNLOCKED = 2'd2;
  localparam logic [1:0] ST_LOCKOUT  = 2'd3;

  // One LFSR step; the all-zero lock-up state is replaced by the seed.
  function automatic logic [STATE_W-1:0] lfsr_advance(input logic [STATE_W-1:0] cur);
    logic                fb;
    logic [STATE_W-1:0]  nxt;
    fb  = ^(cur & TAPS);
    nxt = {cur[STATE_W-2:0], fb};
    if (nxt == {STATE_W{1'b0}}) begin
      return SEED;
    end else begin
      return nxt;
    end
  endfunction

  // Response bits: bit i is the parity of every LFSR bit j with j mod DATA_W == i.
  function automatic logic [DATA_W-1:0] lfsr_fold(input logic [STATE_W-1:0] cur);
    logic [DATA_W-1:0] f;
    f = {DATA_W{1'b0}};
    for (int j = 0; j < STATE_W; j++) begin
      f[j % DATA_W] = f[j % DATA_W] ^ cur[j];
    end
    return f;
  endfunction

  logic [1:0]         state_r,  state_nxt_s;
  logic [STATE_W-1:0] lfsr_r,   lfsr_nxt_s;
  logic [STEP_W-1:0]  step_r,   step_nxt_s;
  logic [FAIL_W-1:0]  fail_r,   fail_nxt_s;
  logic [TIMER_W-1:0] timer_r,  timer_nxt_s;
  logic               unlocked_r;
  logic               locked_out_r;

  logic               acc_s;
  logic               match_s;
  logic [STATE_W-1:0] lfsr_adv_s;

  // Qualify a key-window read and compare the command with the expected nibble.
  always_comb begin
    acc_s      = bus_valid & ~sser_n & ~ba13 & ba12 & br_w;
    match_s    = (ba_cmd == lfsr_r[ADDR_W-1:0]);
    lfsr_adv_s = lfsr_advance(lfsr_r);
  end

  // Next-state logic for the sequencer and its counters.
  always_comb begin
    state_nxt_s = state_r;
    lfsr_nxt_s  = lfsr_r;
    step_nxt_s  = step_r;
    fail_nxt_s  = fail_r;
    timer_nxt_s = timer_r;
    case (state_r)
      ST_LOCKED, ST_TRACK: begin
        if (acc_s) begin
          if (match_s) begin
            lfsr_nxt_s = lfsr_adv_s;
            if (step_r == STEP_LAST) begin
              state_nxt_s = ST_UNLOCKED;
              step_nxt_s  = {STEP_W{1'b0}};
              fail_nxt_s  = {FAIL_W{1'b0}};
            end else begin
              state_nxt_s = ST_TRACK;
              step_nxt_s  = step_r + STEP_W'(1);
            end
          end else begin
            lfsr_nxt_s = SEED;
            step_nxt_s = {STEP_W{1'b0}};
            fail_nxt_s = fail_r + FAIL_W'(1);
            if (fail_r == FAIL_LAST) begin
              state_nxt_s = ST_LOCKOUT;
              timer_nxt_s = TIMER_LOAD;
            end else begin
              state_nxt_s = ST_LOCKED;
            end
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_UNLOCKED: begin
        if (acc_s) begin
          if (ba_cmd == RELOCK) begin
            state_nxt_s = ST_LOCKED;
            lfsr_nxt_s  = SEED;
            step_nxt_s  = {STEP_W{1'b0}};
          end else begin
            lfsr_nxt_s = lfsr_adv_s;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_LOCKOUT: begin
        // Bus accesses are deliberately ignored while the timer runs.
        if (timer_r == {TIMER_W{1'b0}}) begin
          state_nxt_s = ST_LOCKED;
          fail_nxt_s  = {FAIL_W{1'b0}};
          lfsr_nxt_s  = SEED;
          step_nxt_s  = {STEP_W{1'b0}};
        end else begin
          timer_nxt_s = timer_r - TIMER_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_LOCKED;
        lfsr_nxt_s  = SEED;
        step_nxt_s  = {STEP_W{1'b0}};
        fail_nxt_s  = {FAIL_W{1'b0}};
        timer_nxt_s = {TIMER_W{1'b0}};
      end
    endcase
  end

  // State and counter registers; status flags are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_LOCKED;
      lfsr_r       <= SEED;
      step_r       <= {STEP_W{1'b0}};
      fail_r       <= {FAIL_W{1'b0}};
      timer_r      <= {TIMER_W{1'b0}};
      unlocked_r   <= 1'b0;
      locked_out_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      lfsr_r       <= lfsr_nxt_s;
      step_r       <= step_nxt_s;
      fail_r       <= fail_nxt_s;
      timer_r      <= timer_nxt_s;
      unlocked_r   <= (state_nxt_s == ST_UNLOCKED);
      locked_out_r <= (state_nxt_s == ST_LOCKOUT);
    end
  end

  // Response data comes from the pre-update LFSR so a read sees zero-cycle data.
  always_comb begin
    case (state_r)
      ST_UNLOCKED:         sd_out = lfsr_fold(lfsr_r);
      ST_LOCKED, ST_TRACK: sd_out = ~lfsr_r[DATA_W-1:0];
      ST_LOCKOUT:          sd_out = {DATA_W{1'b0}};
      default:             sd_out = {DATA_W{1'b0}};
    endcase
  end

  assign sd_oe      = acc_s;
  assign unlocked   = unlocked_r;
  assign locked_out = locked_out_r;

endmodule

// File: tb/tb_key_sequencer.sv
// Directed bench for key_sequencer: default 6-bit build plus an 8-bit,
// six-step build checked against a small LFSR model.
`timescale 1ns/1ps
module tb_key_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sser_n = 1'b1;
  logic       ba13 = 1'b0;
  logic       ba12 = 1'b1;
  logic [3:0] ba_cmd = 4'h0;
  logic       br_w = 1'b1;
  logic       bus_valid = 1'b0;

  logic [1:0] sd_out, sd_out8;
  logic       sd_oe, sd_oe8;
  logic       unlocked, unlocked8;
  logic       locked_out, locked_out8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_sequencer dut (
    .clk(clk), .rst(rst), .sser_n(sser_n), .ba13(ba13), .ba12(ba12),
    .ba_cmd(ba_cmd), .br_w(br_w), .bus_valid(bus_valid),
    .sd_out(sd_out), .sd_oe(sd_oe), .unlocked(unlocked), .locked_out(locked_out)
  );

  key_sequencer #(
    .STATE_W(8), .ADDR_W(4), .DATA_W(2), .TAPS(8'hB8), .SEED(8'h2D),
    .SEQ_LEN(6), .MAX_FAIL(3), .LOCKOUT_CYC(16), .RELOCK(4'hF)
  ) dut8 (
    .clk(clk), .rst(rst), .sser_n(sser_n), .ba13(ba13), .ba12(ba12),
    .ba_cmd(ba_cmd), .br_w(br_w), .bus_valid(bus_valid),
    .sd_out(sd_out8), .sd_oe(sd_oe8), .unlocked(unlocked8), .locked_out(locked_out8)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle; returns the combinational response sampled before the edge.
  task automatic bus_op(input logic [3:0] cmd, input logic rd, input logic b13,
                        output logic [1:0] so, output logic oe,
                        output logic [1:0] so8, output logic oe8);
    @(negedge clk);
    ba_cmd = cmd; br_w = rd; ba13 = b13; ba12 = 1'b1; sser_n = 1'b0; bus_valid = 1'b1;
    #1;
    so = sd_out; oe = sd_oe; so8 = sd_out8; oe8 = sd_oe8;
    @(posedge clk);
    #1;
    bus_valid = 1'b0; sser_n = 1'b1; br_w = 1'b1; ba13 = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  function automatic logic [7:0] model_adv8(input logic [7:0] s);
    logic [7:0] n;
    n = {s[6:0], ^(s & 8'hB8)};
    return (n == 8'h00) ? 8'h2D : n;
  endfunction

  logic [1:0] so, so8;
  logic       oe, oe8;
  logic [3:0] unlock_seq [4];
  logic [7:0] m;
  int         cnt;

  initial begin
    unlock_seq[0] = 4'hD; unlock_seq[1] = 4'hB; unlock_seq[2] = 4'h7; unlock_seq[3] = 4'hE;

    // Reset state
    rst = 1'b1;
    #12;
    check_val("rst_unlocked", {31'd0, unlocked}, 32'd0);
    check_val("rst_locked_out", {31'd0, locked_out}, 32'd0);
    check_val("rst_sd_oe", {31'd0, sd_oe}, 32'd0);
    check_val("rst_sd_out", {30'd0, sd_out}, 32'h2);
    rst = 1'b0;

    // Correct sequence, checking decoy data on every read
    bus_op(4'hD, 1'b1, 1'b0, so, oe, so8, oe8);
    check_val("decoy_seed_oe", {31'd0, oe}, 32'd1);
    check_val("decoy_seed", {30'd0, so}, 32'h2);
    check_val("step1_unlocked", {31'd0, unlocked}, 32'd0);
    bus_op(4'hB, 1'b1, 1'b0, so, oe, so8, oe8);
    check_val("decoy_1b", {30'd0, so}, 32'h0);
    bus_op(4'h7, 1'b1, 1'b0, so, oe, so8, oe8);
    check_val("decoy_37", {30'd0, so}, 32'h0);
    check_val("step3_unlocked", {31'd0, unlocked}, 32'd0);
    bus_op(4'hE, 1'b1, 1'b0, so, oe, so8, oe8);
    check_val("decoy_2e", {30'd0, so}, 32'h1);
    check_val("unlock_flag", {31'd0, unlocked}, 32'd1);
    check_val("unlock_lfsr", {26'd0, dut.lfsr_r}, 32'h1D);

    // Stream read and relock
    bus_op(4'h0, 1'b1, 1'b0, so, oe, so8, oe8);
    check_val("stream_sd_out", {30'd0, so}, 32'h3);
    check_val("stream_oe", {31'd0, oe}, 32'd1);
    check_val("stream_lfsr", {26'd0, dut.lfsr_r}, 32'h3B);
    bus_op(4'hF, 1'b1, 1'b0, so, oe, so8, oe8);
    check_val("relock_sd_out", {30'd0, so}, 32'h2);
    check_val("relock_unlocked", {31'd0, unlocked}, 32'd0);
    check_val("relock_lfsr", {26'd0, dut.lfsr_r}, 32'h2D);

    // Ignored cycles: a write and an out-of-window read
    bus_op(4'hD, 1'b0, 1'b0, so, oe, so8, oe8);
    check_val("write_oe", {31'd0, oe}, 32'd0);
    bus_op(4'hD, 1'b1, 1'b1, so, oe, so8, oe8);
    check_val("ba13_oe", {31'd0, oe}, 32'd0);
    check_val("ignored_lfsr", {26'd0, dut.lfsr_r}, 32'h2D);
    check_val("ignored_step", {29'd0, dut.step_r}, 32'd0);

    // Partial sequence with a wrong third command
    bus_op(4'hD, 1'b1, 1'b0, so, oe, so8, oe8);
    bus_op(4'hB, 1'b1, 1'b0, so, oe, so8, oe8);
    bus_op(4'h3, 1'b1, 1'b0, so, oe, so8, oe8);
    check_val("miss_lfsr", {26'd0, dut.lfsr_r}, 32'h2D);
    check_val("miss_fail", {30'd0, dut.fail_r}, 32'd1);
    check_val("miss_step", {29'd0, dut.step_r}, 32'd0);
    check_val("miss_unlocked", {31'd0, unlocked}, 32'd0);
    for (int i = 0; i < 4; i++) bus_op(unlock_seq[i], 1'b1, 1'b0, so, oe, so8, oe8);
    check_val("retry_unlocked", {31'd0, unlocked}, 32'd1);
    check_val("retry_fail", {30'd0, dut.fail_r}, 32'd0);
    bus_op(4'hF, 1'b1, 1'b0, so, oe, so8, oe8);

    // Three failures force lockout
    bus_op(4'h0, 1'b1, 1'b0, so, oe, so8, oe8);
    bus_op(4'h0, 1'b1, 1'b0, so, oe, so8, oe8);
    check_val("fail2_locked_out", {31'd0, locked_out}, 32'd0);
    bus_op(4'h0, 1'b1, 1'b0, so, oe, so8, oe8);
    check_val("lockout_entry", {31'd0, locked_out}, 32'd1);
    bus_op(4'hD, 1'b1, 1'b0, so, oe, so8, oe8);
    check_val("lockout_sd_out", {30'd0, so}, 32'h0);
    check_val("lockout_step", {29'd0, dut.step_r}, 32'd0);
    cnt = 1;
    while (locked_out && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_val("lockout_len", cnt, 32'd16);
    check_val("lockout_exit_fail", {30'd0, dut.fail_r}, 32'd0);
    check_val("lockout_exit_lfsr", {26'd0, dut.lfsr_r}, 32'h2D);
    for (int i = 0; i < 4; i++) bus_op(unlock_seq[i], 1'b1, 1'b0, so, oe, so8, oe8);
    check_val("post_lockout_unlock", {31'd0, unlocked}, 32'd1);
    bus_op(4'hF, 1'b1, 1'b0, so, oe, so8, oe8);

    // Reset mid-sequence discards progress
    bus_op(4'hD, 1'b1, 1'b0, so, oe, so8, oe8);
    bus_op(4'hB, 1'b1, 1'b0, so, oe, so8, oe8);
    pulse_rst();
    check_val("midrst_step", {29'd0, dut.step_r}, 32'd0);
    check_val("midrst_lfsr", {26'd0, dut.lfsr_r}, 32'h2D);
    for (int i = 0; i < 4; i++) bus_op(unlock_seq[i], 1'b1, 1'b0, so, oe, so8, oe8);
    check_val("midrst_unlock", {31'd0, unlocked}, 32'd1);

    // 8-bit, six-step build against the model
    pulse_rst();
    m = 8'h2D;
    for (int k = 0; k < 6; k++) begin
      bus_op(m[3:0], 1'b1, 1'b0, so, oe, so8, oe8);
      check_val("w8_decoy", {30'd0, so8}, {30'd0, ~m[1:0]});
      m = model_adv8(m);
      check_val("w8_unlocked", {31'd0, unlocked8}, (k == 5) ? 32'd1 : 32'd0);
    end
    check_val("w8_lfsr", {24'd0, dut8.lfsr_r}, {24'd0, m});
    bus_op(4'h0, 1'b1, 1'b0, so, oe, so8, oe8);
    check_val("w8_stream", {30'd0, so8},
              {30'd0, m[1] ^ m[3] ^ m[5] ^ m[7], m[0] ^ m[2] ^ m[4] ^ m[6]});
    m = model_adv8(m);
    check_val("w8_stream_lfsr", {24'd0, dut8.lfsr_r}, {24'd0, m});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
